// File: rtl/spi_regbank_arbiter.sv
// rtl/spi_regbank_arbiter.sv - two-port req/ack arbiter that owns the device register bank
// Optional ARB_ROUND_ROBIN_EN: round-robin arbitration; otherwise fixed priority with port A winning.
module spi_regbank_arbiter #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           a_req,
    input  logic                           a_we,
    input  logic [ADDR_W-1:0]              a_addr,
    input  logic [DATA_W-1:0]              a_wdata,
    output logic                           a_ack,
    output logic [DATA_W-1:0]              a_rdata,
    input  logic                           b_req,
    input  logic                           b_we,
    input  logic [ADDR_W-1:0]              b_addr,
    input  logic [DATA_W-1:0]              b_wdata,
    output logic                           b_ack,
    output logic [DATA_W-1:0]              b_rdata,
    output logic [1:0]                     grant,
    output logic [(2**ADDR_W)*DATA_W-1:0]  regs_flat
);
    localparam int NREG = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t              state_q, state_d;
    logic [1:0]          grant_q, grant_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                a_ack_q, a_ack_d;
    logic                b_ack_q, b_ack_d;
    logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;
    logic [DATA_W-1:0]   regs_q [NREG];
    logic [DATA_W-1:0]   regs_d [NREG];
    logic                pick_b;
`ifdef ARB_ROUND_ROBIN_EN
    logic                prefer_b_q, prefer_b_d;
`endif

    function automatic logic [DATA_W-1:0] reset_val(input int k);
        case (k)
            0:       reset_val = DATA_W'(8'h96);
            1:       reset_val = DATA_W'(8'h01);
            2:       reset_val = DATA_W'(8'h02);
            3:       reset_val = DATA_W'(8'h03);
            default: reset_val = '0;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        a_ack_d   = 1'b0;
        b_ack_d   = 1'b0;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        regs_d    = regs_q;
        pick_b    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        prefer_b_d = prefer_b_q;
`endif
        case (state_q)
            IDLE: begin
                if (a_req || b_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                    pick_b     = b_req && (!a_req || prefer_b_q);
                    prefer_b_d = !pick_b;
`else
                    pick_b = b_req && !a_req;
`endif
                    grant_d = pick_b ? 2'b10 : 2'b01;
                    we_d    = pick_b ? b_we    : a_we;
                    addr_d  = pick_b ? b_addr  : a_addr;
                    wdata_d = pick_b ? b_wdata : a_wdata;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // Access uses only the fields latched at grant, so a dropped req is harmless.
                if (we_q) begin
                    regs_d[addr_q] = wdata_q;
                end else if (grant_q[1]) begin
                    b_rdata_d = regs_q[addr_q];
                end else begin
                    a_rdata_d = regs_q[addr_q];
                end
                if (grant_q[1]) begin
                    b_ack_d = 1'b1;
                end else begin
                    a_ack_d = 1'b1;
                end
                grant_d = 2'b00;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= 2'b00;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
            for (int k = 0; k < NREG; k++) begin
                regs_q[k] <= reset_val(k);
            end
`ifdef ARB_ROUND_ROBIN_EN
            prefer_b_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            a_ack_q   <= a_ack_d;
            b_ack_q   <= b_ack_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
            regs_q    <= regs_d;
`ifdef ARB_ROUND_ROBIN_EN
            prefer_b_q <= prefer_b_d;
`endif
        end
    end

    assign a_ack   = a_ack_q;
    assign b_ack   = b_ack_q;
    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;
    assign grant   = grant_q;

    for (genvar g = 0; g < NREG; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
    end

endmodule

// File: tb/tb_spi_regbank_arbiter.sv
// tb/tb_spi_regbank_arbiter.sv - directed self-checking bench for spi_regbank_arbiter
module tb_spi_regbank_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req, a_we, b_req, b_we;
    logic [1:0]  a_addr, b_addr;
    logic [7:0]  a_wdata, b_wdata;
    logic        a_ack, b_ack;
    logic [7:0]  a_rdata, b_rdata;
    logic [1:0]  grant;
    logic [31:0] regs_flat;
    int          checks = 0;
    int          errors = 0;

    spi_regbank_arbiter #(.ADDR_W(2), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .grant(grant), .regs_flat(regs_flat)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] reg_of(input int k);
        return regs_flat[k*8 +: 8];
    endfunction

    initial begin
        rst_n = 1'b0;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        check("rst_regs", regs_flat, 32'h03020196);
        check("rst_a_ack", a_ack, 0);
        check("rst_b_ack", b_ack, 0);
        check("rst_grant", grant, 2'b00);
        check("rst_a_rdata", a_rdata, 0);
        check("rst_b_rdata", b_rdata, 0);

        // A writes 0x5A to addr 2, dropping req right after grant
        a_req = 1; a_we = 1; a_addr = 2; a_wdata = 8'h5A;
        cyc(1);
        check("wr_grant", grant, 2'b01);
        check("wr_ack_early", a_ack, 0);
        a_req = 0;
        cyc(1);
        check("wr_ack", a_ack, 1);
        check("wr_grant_clr", grant, 2'b00);
        check("wr_reg2", reg_of(2), 8'h5A);
        cyc(1);
        check("wr_ack_pulse", a_ack, 0);

        // A reads addr 2
        a_req = 1; a_we = 0; a_addr = 2;
        cyc(1);
        check("rd_grant", grant, 2'b01);
        a_req = 0;
        cyc(1);
        check("rd_ack", a_ack, 1);
        check("rd_data", a_rdata, 8'h5A);
        cyc(1);
        check("rd_data_hold", a_rdata, 8'h5A);

        // simultaneous: A writes 0x11 to addr 1, B reads addr 1
        a_req = 1; a_we = 1; a_addr = 1; a_wdata = 8'h11;
        b_req = 1; b_we = 0; b_addr = 1;
`ifdef ARB_ROUND_ROBIN_EN
        cyc(1);
        check("sim_grant1", grant, 2'b10);
        b_req = 0;
        cyc(1);
        check("sim_b_ack", b_ack, 1);
        check("sim_b_rdata", b_rdata, 8'h01);
        check("sim_a_wait", a_ack, 0);
        cyc(2);
        check("sim_grant2", grant, 2'b01);
        a_req = 0;
        cyc(1);
        check("sim_a_ack", a_ack, 1);
        check("sim_reg1", reg_of(1), 8'h11);
`else
        cyc(1);
        check("sim_grant1", grant, 2'b01);
        a_req = 0;
        cyc(1);
        check("sim_a_ack", a_ack, 1);
        check("sim_reg1", reg_of(1), 8'h11);
        check("sim_b_wait", b_ack, 0);
        cyc(2);
        check("sim_grant2", grant, 2'b10);
        b_req = 0;
        cyc(1);
        check("sim_b_ack", b_ack, 1);
        check("sim_b_rdata", b_rdata, 8'h11);
`endif
        cyc(1);

        // both write addr 3 at once
        a_req = 1; a_we = 1; a_addr = 3; a_wdata = 8'hAA;
        b_req = 1; b_we = 1; b_addr = 3; b_wdata = 8'hBB;
`ifdef ARB_ROUND_ROBIN_EN
        cyc(1);
        b_req = 0;
        cyc(1);
        check("ww_first_ack", b_ack, 1);
        cyc(2);
        a_req = 0;
        cyc(1);
        check("ww_second_ack", a_ack, 1);
        check("ww_reg3", reg_of(3), 8'hAA);
`else
        cyc(1);
        a_req = 0;
        cyc(1);
        check("ww_first_ack", a_ack, 1);
        check("ww_reg3_mid", reg_of(3), 8'hAA);
        cyc(2);
        b_req = 0;
        cyc(1);
        check("ww_second_ack", b_ack, 1);
        check("ww_reg3", reg_of(3), 8'hBB);
`endif
        cyc(1);

        // reset in the ACCESS cycle of an A write
        a_req = 1; a_we = 1; a_addr = 0; a_wdata = 8'h77;
        cyc(1);
        check("rstm_grant", grant, 2'b01);
        rst_n = 1'b0;
        #1;
        check("rstm_grant_clr", grant, 2'b00);
        a_req = 0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        check("rstm_no_ack", a_ack, 0);
        cyc(1);
        check("rstm_no_ack2", a_ack, 0);
        check("rstm_regs", regs_flat, 32'h03020196);

        // both hold req continuously
        a_req = 1; a_we = 0; a_addr = 0;
        b_req = 1; b_we = 0; b_addr = 1;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
`ifdef ARB_ROUND_ROBIN_EN
            check($sformatf("fair_grant%0d", i), grant, (i % 2) ? 2'b10 : 2'b01);
`else
            check($sformatf("fair_grant%0d", i), grant, 2'b01);
`endif
            cyc(2);
        end
        a_req = 0;
        cyc(1);
        check("fair_grant_b", grant, 2'b10);
        b_req = 0;
        cyc(1);
        check("fair_b_ack", b_ack, 1);
        check("fair_b_rdata", b_rdata, 8'h01);
        check("fair_a_rdata", a_rdata, 8'h96);
        cyc(2);
        check("end_grant", grant, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
